// File: rtl/wb_arb_pkg.sv
// ---------------------------------------------------------------------------
// wb_arb_pkg
// Shared types and constants for the two-master Wishbone arbiter.
//   grant_state_e : arbiter grant state (IDLE / GNT_M0 / GNT_M1)
//   GRANT_*       : one-hot grant_o encodings, bit order {m1,m0}
//   ADDR_WIDTH_DEFAULT : default Wishbone address width
// ---------------------------------------------------------------------------
package wb_arb_pkg;

    localparam int ADDR_WIDTH_DEFAULT = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GNT_M0 = 2'b01,
        GNT_M1 = 2'b10
    } grant_state_e;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/wb_arb_watchdog.sv
// ---------------------------------------------------------------------------
// wb_watchdog
// Counts consecutive cycles in which the granted master has a strobe
// outstanding with no slave termination, and pulses expire on the cycle
// that would be the TIMEOUT_CYCLES-th such cycle.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   enable        : strobe pending and not terminated this cycle
//   clear         : force the count back to zero (idle, termination, no stb)
//   expire        : one-cycle pulse when the stall limit is reached
// TIMEOUT_CYCLES = 0 disables the watchdog entirely.
// ---------------------------------------------------------------------------
module wb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam bit                     ACTIVE = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_WIDTH-1:0] LIMIT  = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);

    logic [TIMEOUT_WIDTH-1:0] count;
    logic [TIMEOUT_WIDTH:0]   count_inc;

    // The current stalled cycle is included in the comparison, so the
    // pulse lands on the TIMEOUT_CYCLES-th stalled cycle itself.
    assign count_inc = {1'b0, count} + (TIMEOUT_WIDTH + 1)'(1);
    assign expire    = ACTIVE && enable && !clear && (count_inc == {1'b0, LIMIT});

    // Stall counter: clears on expiry or any clear condition and saturates
    // at the limit instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (!ACTIVE || clear || !enable || expire) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + TIMEOUT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// ---------------------------------------------------------------------------
// wb_master_arbiter
// Round-robin arbiter giving two Wishbone B4 classic masters access to one
// shared 8-bit memory bus. A grant is held for the master's whole cycle
// (cyc high), and a watchdog forces an err on hung strobes.
// Ports:
//   clk_i, rst_ni                    : clock, asynchronous active-low reset
//   m{0,1}_cyc/stb/we/adr/dat_i      : master requests
//   m{0,1}_dat/ack/err/rty_o         : master returns, zero when not granted
//   s_cyc/stb/we/adr/dat_o           : shared bus request side
//   s_dat/ack/err/rty_i              : shared bus return side
//   grant_o                          : one-hot current grant {m1,m0}
//   timeout_o                        : pulse when the watchdog fires
// ---------------------------------------------------------------------------
module wb_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEFAULT,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [7:0]            m0_dat_i,
    output logic [7:0]            m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    output logic                  m0_rty_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [7:0]            m1_dat_i,
    output logic [7:0]            m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  m1_rty_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [7:0]            s_dat_o,
    input  logic [7:0]            s_dat_i,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,
    input  logic                  s_rty_i,
    output logic [1:0]            grant_o,
    output logic                  timeout_o
);

    grant_state_e state;
    logic         last_grant;
    logic         sel_m0;
    logic         sel_m1;
    logic         sel_cyc;
    logic         sel_stb;
    logic         slave_term;
    logic         stalled;
    logic         expire;

    // Grant FSM: in IDLE a tie goes to the master that did not have the
    // last grant; a grant is released only when its owner drops cyc, and
    // always passes through IDLE so grant switches never have zero gap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_cyc_i && m1_cyc_i) begin
                        state <= last_grant ? GNT_M0 : GNT_M1;
                    end else if (m0_cyc_i) begin
                        state <= GNT_M0;
                    end else if (m1_cyc_i) begin
                        state <= GNT_M1;
                    end
                end
                GNT_M0: begin
                    if (!m0_cyc_i) begin
                        state      <= IDLE;
                        last_grant <= 1'b0;
                    end
                end
                GNT_M1: begin
                    if (!m1_cyc_i) begin
                        state      <= IDLE;
                        last_grant <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sel_m0 = (state == GNT_M0);
    assign sel_m1 = (state == GNT_M1);

    // Request-side mux: the granted master drives the shared bus; in IDLE
    // everything stays at zero.
    always_comb begin
        sel_cyc = 1'b0;
        sel_stb = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        if (sel_m0) begin
            sel_cyc = m0_cyc_i;
            sel_stb = m0_stb_i;
            s_we_o  = m0_we_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
        end else if (sel_m1) begin
            sel_cyc = m1_cyc_i;
            sel_stb = m1_stb_i;
            s_we_o  = m1_we_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
        end
    end

    // The stall condition uses the master's own strobe, not the forced bus
    // strobe, so blanking cyc/stb on expiry does not feed back into it.
    assign slave_term = s_ack_i | s_err_i | s_rty_i;
    assign stalled    = sel_cyc & sel_stb & ~slave_term;

    wb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
    ) u_watchdog (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .enable(stalled),
        .clear (~sel_cyc | ~sel_stb | slave_term),
        .expire(expire)
    );

    assign s_cyc_o   = sel_cyc & ~expire;
    assign s_stb_o   = sel_cyc & sel_stb & ~expire;
    assign timeout_o = expire;

    // Return-side routing: only the granted master sees slave responses;
    // a watchdog expiry shows up as err on that master.
    assign m0_dat_o = sel_m0 ? s_dat_i : 8'h00;
    assign m0_ack_o = sel_m0 & s_ack_i;
    assign m0_err_o = sel_m0 & (s_err_i | expire);
    assign m0_rty_o = sel_m0 & s_rty_i;
    assign m1_dat_o = sel_m1 ? s_dat_i : 8'h00;
    assign m1_ack_o = sel_m1 & s_ack_i;
    assign m1_err_o = sel_m1 & (s_err_i | expire);
    assign m1_rty_o = sel_m1 & s_rty_i;

    assign grant_o = sel_m0 ? GRANT_M0 : (sel_m1 ? GRANT_M1 : GRANT_NONE);

endmodule
